icw_sequencer: RTL and testbench
================================

# icw_sequencer

Initialization/operation command-word sequencer for the 8259A control logic. It decodes each CPU write from the read/write logic (A0 plus the internal data bus) and steps through the ICW1 → ICW2 → [ICW3] → [ICW4] sequence. It produces the one-hot write strobes consumed by the ICW4 register, the IMR and the OCW registers, and latches the ICW1/ICW2/ICW3 configuration fields. It sits between the bus-interface write decode and the command-word registers.

## Interface
- No parameters.
- `clock`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `write_enable`  in  1  single-cycle pulse, one per CPU write
- `address`  in  1  A0 of the write
- `internal_data_bus`  in  8  write data
- `write_initial_command_word_1` … `_4`  out  1 each  combinational ICW strobes
- `write_operation_control_word_1` … `_3`  out  1 each  combinational OCW strobes
- `level_or_edge_triggered_config`  out  1  ICW1 D3 (LTIM)
- `call_address_interval_4_config`  out  1  ICW1 D2 (ADI)
- `single_or_cascade_config`  out  1  ICW1 D1 (SNGL)
- `set_icw4_config`  out  1  ICW1 D0 (IC4)
- `vector_address_low`  out  3  ICW1 D7:5
- `interrupt_vector_address`  out  8  ICW2 byte
- `cascade_device_config`  out  8  ICW3 byte
- `initialization_done`  out  1  sequence complete; OCWs accepted

## Operation
- States: `CMD_READY`, `WRITE_ICW2`, `WRITE_ICW3`, `WRITE_ICW4`.
- Reset:
  - state `CMD_READY`.
  - All config outputs 0; `initialization_done` 0.
  - No strobes while `reset_n` is low.
- Decode rules apply only when `write_enable` = 1, in the order below.
- ICW1: A0=0, D4=1, in any state, including mid-sequence.
  - Asserts `write_initial_command_word_1`.
  - Latches D7:5, D3, D2, D1, D0.
  - Clears `cascade_device_config` and `initialization_done`.
  - Next state `WRITE_ICW2`.
- A0=1 in `WRITE_ICW2`:
  - Asserts `write_initial_command_word_2` and latches `interrupt_vector_address`.
  - Next state: `WRITE_ICW3` if SNGL=0; else `WRITE_ICW4` if IC4=1; else `CMD_READY` with done←1.
- A0=1 in `WRITE_ICW3`:
  - Asserts `write_initial_command_word_3` and latches `cascade_device_config`.
  - Next state: `WRITE_ICW4` if IC4=1, else `CMD_READY` with done←1.
- A0=1 in `WRITE_ICW4`:
  - Asserts `write_initial_command_word_4`.
  - Next state `CMD_READY`; done←1.
- A0=1 in `CMD_READY`: asserts `write_operation_control_word_1`, only if done=1.
- A0=0, D4=0 in `CMD_READY` with done=1:
  - D3=0 → `write_operation_control_word_2`.
  - D3=1 → `write_operation_control_word_3`.
- A0=0, D4=0 while in any `WRITE_ICWx` state: ignored. No strobe, no state change.
- Any OCW while done=0: ignored.
- SNGL/IC4 branch decisions use the registered ICW1 values latched at the ICW1 edge.

## Timing
- Strobes are combinational from `write_enable`, `address`, `internal_data_bus` and current state. They are high in the same cycle as `write_enable`, for exactly that cycle.
- State, config registers and `initialization_done` update on the rising `clock` edge that samples `write_enable`. New values are visible the following cycle.
- At most one strobe is high in any cycle.
- Back-to-back writes on consecutive cycles are supported, with no idle cycle required.
- ICW1 while `WRITE_ICW3` is pending aborts the sequence:
  - restart at `WRITE_ICW2`;
  - the old ICW2 value stays in `interrupt_vector_address` until overwritten.
- `reset_n` falling mid-sequence: immediate return to reset values, independent of `clock`.
- Deassertion of `reset_n` is synchronized externally; the block has no requirement on it.

## Structure
- Shared `pic_8259a_pkg` holds:
  - the state enum `icw_state_t`;
  - bit-position constants `ICW1_IC4`=0, `ICW1_SNGL`=1, `ICW1_ADI`=2, `ICW1_LTIM`=3, `ICW1_SEL`=4, `OCW_SEL`=3.
- One module, no sub-modules.
- Config capture and the next-state decode are separate processes within the module.

## Test plan
- Reset, then A0=0 D=0x13 (ICW1: SNGL=1, IC4=1), then A0=1 0x20, then A0=1 0x01 → strobes ICW1, ICW2, ICW4 in that order; ICW3 is skipped; `interrupt_vector_address`=0x20; done=1 after the third write.
- A0=0 0x10, then A0=1 0x08, then A0=1 0x04 (cascade, no ICW4) → ICW3 strobe fires; `cascade_device_config`=0x04; done=1; no ICW4 strobe.
- Before done=1: A0=1 0xFF and A0=0 0x20 → no OCW strobes. After init: same writes → OCW1, then OCW2; A0=0 0x0B → OCW3.
- ICW1 written while in `WRITE_ICW3` → state returns to `WRITE_ICW2`; `cascade_device_config`=0; done=0.
- Pulse `reset_n` low between ICW2 and ICW4 → all outputs 0 immediately; the next A0=1 write produces no strobe.
- Four back-to-back `write_enable` cycles (0x11, 0x40, 0x02, 0x03) → exactly one strobe per cycle: ICW1, ICW2, ICW3, ICW4.

Source files
------------

// File: rtl/pic_8259a_pkg.sv
// pic_8259a_pkg: shared types and bit positions for the 8259A control logic.
package pic_8259a_pkg;
    typedef enum logic [1:0] {CMD_READY, WRITE_ICW2, WRITE_ICW3, WRITE_ICW4} icw_state_t;
    localparam int ICW1_IC4  = 0;
    localparam int ICW1_SNGL = 1;
    localparam int ICW1_ADI  = 2;
    localparam int ICW1_LTIM = 3;
    localparam int ICW1_SEL  = 4;
    localparam int OCW_SEL   = 3;
endpackage

// File: rtl/icw_sequencer.sv
// icw_sequencer: decodes CPU writes into ICW/OCW strobes and walks the ICW1..ICW4 init sequence.
import pic_8259a_pkg::*;
module icw_sequencer (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       write_enable,
    input  logic       address,
    input  logic [7:0] internal_data_bus,
    output logic       write_initial_command_word_1,
    output logic       write_initial_command_word_2,
    output logic       write_initial_command_word_3,
    output logic       write_initial_command_word_4,
    output logic       write_operation_control_word_1,
    output logic       write_operation_control_word_2,
    output logic       write_operation_control_word_3,
    output logic       level_or_edge_triggered_config,
    output logic       call_address_interval_4_config,
    output logic       single_or_cascade_config,
    output logic       set_icw4_config,
    output logic [2:0] vector_address_low,
    output logic [7:0] interrupt_vector_address,
    output logic [7:0] cascade_device_config,
    output logic       initialization_done
);
    icw_state_t state;
    logic       wr;
    logic       cmd_ocw;
    always_comb begin
        wr = write_enable & reset_n;
        // A0=0 with D4=0 is an OCW2/OCW3, valid only once initialization has completed
        cmd_ocw = wr & ~address & ~internal_data_bus[ICW1_SEL] & (state == CMD_READY) & initialization_done;
        write_initial_command_word_1   = wr & ~address & internal_data_bus[ICW1_SEL];
        write_initial_command_word_2   = wr & address & (state == WRITE_ICW2);
        write_initial_command_word_3   = wr & address & (state == WRITE_ICW3);
        write_initial_command_word_4   = wr & address & (state == WRITE_ICW4);
        write_operation_control_word_1 = wr & address & (state == CMD_READY) & initialization_done;
        write_operation_control_word_2 = cmd_ocw & ~internal_data_bus[OCW_SEL];
        write_operation_control_word_3 = cmd_ocw & internal_data_bus[OCW_SEL];
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state               <= CMD_READY;
            initialization_done <= 1'b0;
        end else if (write_initial_command_word_1) begin
            state               <= WRITE_ICW2;
            initialization_done <= 1'b0;
        end else if (write_initial_command_word_2) begin
            state               <= !single_or_cascade_config ? WRITE_ICW3 :
                                   set_icw4_config ? WRITE_ICW4 : CMD_READY;
            initialization_done <= single_or_cascade_config & ~set_icw4_config;
        end else if (write_initial_command_word_3) begin
            state               <= set_icw4_config ? WRITE_ICW4 : CMD_READY;
            initialization_done <= ~set_icw4_config;
        end else if (write_initial_command_word_4) begin
            state               <= CMD_READY;
            initialization_done <= 1'b1;
        end
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level_or_edge_triggered_config <= 1'b0;
            call_address_interval_4_config <= 1'b0;
            single_or_cascade_config       <= 1'b0;
            set_icw4_config                <= 1'b0;
            vector_address_low             <= 3'd0;
            interrupt_vector_address       <= 8'd0;
            cascade_device_config          <= 8'd0;
        end else if (write_initial_command_word_1) begin
            level_or_edge_triggered_config <= internal_data_bus[ICW1_LTIM];
            call_address_interval_4_config <= internal_data_bus[ICW1_ADI];
            single_or_cascade_config       <= internal_data_bus[ICW1_SNGL];
            set_icw4_config                <= internal_data_bus[ICW1_IC4];
            vector_address_low             <= internal_data_bus[7:5];
            cascade_device_config          <= 8'd0;
        end else if (write_initial_command_word_2) begin
            interrupt_vector_address       <= internal_data_bus;
        end else if (write_initial_command_word_3) begin
            cascade_device_config          <= internal_data_bus;
        end
    end
endmodule

// File: tb/tb_icw_sequencer.sv
// tb_icw_sequencer: scoreboard bench with a behavioural 8259A init-sequence model.
module tb_icw_sequencer;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       write_enable = 1'b0;
    logic       address = 1'b0;
    logic [7:0] internal_data_bus = 8'd0;
    logic       icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3;
    logic       ltim, adi, sngl, ic4, done;
    logic [2:0] vla;
    logic [7:0] iva, cas;

    icw_sequencer dut (
        .clock(clock), .reset_n(reset_n), .write_enable(write_enable),
        .address(address), .internal_data_bus(internal_data_bus),
        .write_initial_command_word_1(icw1), .write_initial_command_word_2(icw2),
        .write_initial_command_word_3(icw3), .write_initial_command_word_4(icw4),
        .write_operation_control_word_1(ocw1), .write_operation_control_word_2(ocw2),
        .write_operation_control_word_3(ocw3),
        .level_or_edge_triggered_config(ltim), .call_address_interval_4_config(adi),
        .single_or_cascade_config(sngl), .set_icw4_config(ic4),
        .vector_address_low(vla), .interrupt_vector_address(iva),
        .cascade_device_config(cas), .initialization_done(done)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    logic [6:0]  q_strobe[$];
    logic [23:0] q_cfg[$];
    bit          in_rst = 1'b1;

    // model: stage 0 = idle/ready, otherwise the number of the next expected ICW
    int         m_stage;
    bit         m_done, m_ltim, m_adi, m_sngl, m_ic4;
    logic [2:0] m_vla;
    logic [7:0] m_iva, m_cas;

    function automatic logic [6:0] dut_strobes();
        return {ocw3, ocw2, ocw1, icw4, icw3, icw2, icw1};
    endfunction

    function automatic logic [23:0] dut_cfg();
        return {vla, ltim, adi, sngl, ic4, iva, cas, done};
    endfunction

    function automatic logic [23:0] model_cfg();
        return {m_vla, m_ltim, m_adi, m_sngl, m_ic4, m_iva, m_cas, m_done};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stage = 0; m_done = 0; m_ltim = 0; m_adi = 0; m_sngl = 0; m_ic4 = 0;
        m_vla = 0; m_iva = 0; m_cas = 0;
    endtask

    task automatic model_write(input bit a0, input logic [7:0] d, output logic [6:0] s);
        s = '0;
        if (!a0 && d[4]) begin
            s[0] = 1; m_vla = d[7:5]; m_ltim = d[3]; m_adi = d[2]; m_sngl = d[1]; m_ic4 = d[0];
            m_cas = 0; m_done = 0; m_stage = 2;
        end else if (a0 && m_stage == 2) begin
            s[1] = 1; m_iva = d;
            m_stage = !m_sngl ? 3 : (m_ic4 ? 4 : 0);
            m_done = (m_stage == 0);
        end else if (a0 && m_stage == 3) begin
            s[2] = 1; m_cas = d;
            m_stage = m_ic4 ? 4 : 0;
            m_done = (m_stage == 0);
        end else if (a0 && m_stage == 4) begin
            s[3] = 1; m_stage = 0; m_done = 1;
        end else if (a0 && m_done) begin
            s[4] = 1;
        end else if (!a0 && m_stage == 0 && m_done) begin
            if (d[3]) s[6] = 1; else s[5] = 1;
        end
    endtask

    // one write per call; consecutive calls give back-to-back write cycles
    task automatic write(input bit a0, input logic [7:0] d);
        logic [6:0] s;
        write_enable = 1; address = a0; internal_data_bus = d;
        model_write(a0, d, s);
        q_strobe.push_back(s);
        q_cfg.push_back(model_cfg());
        @(posedge clock); #1;
    endtask

    task automatic idle(input int n);
        write_enable = 0;
        repeat (n) begin @(posedge clock); #1; end
    endtask

    // monitor: strobes are checked in the write cycle, the config the cycle after
    logic [23:0] pend_cfg;
    bit          pend = 0;
    always @(negedge clock) begin
        if (pend) begin
            check("config", {8'd0, dut_cfg()}, {8'd0, pend_cfg});
            pend = 0;
        end
        if (!in_rst) begin
            if (write_enable) begin
                if (q_strobe.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    check("strobes", {25'd0, dut_strobes()}, {25'd0, q_strobe.pop_front()});
                    pend_cfg = q_cfg.pop_front();
                    pend = 1;
                end
            end else begin
                check("idle_strobes", {25'd0, dut_strobes()}, 32'd0);
            end
        end
    end

    initial begin
        model_reset();
        #3;
        check("reset_cfg", {8'd0, dut_cfg()}, 32'd0);
        write_enable = 1; address = 1; internal_data_bus = 8'h13;
        #1;
        check("reset_strobes", {25'd0, dut_strobes()}, 32'd0);
        write_enable = 0;
        @(posedge clock); #1;
        reset_n = 1;
        @(posedge clock); #1;
        in_rst = 0;
        // single, with ICW4
        write(0, 8'h13); write(1, 8'h20); write(1, 8'h01); idle(2);
        check("iva_0x20", {24'd0, iva}, 32'h20);
        check("done_single", {31'd0, done}, 32'd1);
        // cascade, no ICW4, with OCW rejection before done
        write(0, 8'h10); write(1, 8'hFF); idle(1); write(0, 8'h20); idle(1);
        write(0, 8'h10); write(1, 8'h08); write(1, 8'h04); idle(2);
        check("cas_0x04", {24'd0, cas}, 32'h04);
        write(1, 8'hFF); write(0, 8'h20); write(0, 8'h0B); idle(1);
        // abort from ICW3 pending
        write(0, 8'h10); write(1, 8'h08); write(0, 8'h13); idle(2);
        check("abort_cas", {24'd0, cas}, 32'd0);
        check("abort_iva_kept", {24'd0, iva}, 32'h08);
        write(1, 8'h30); write(1, 8'h02); idle(1);
        // ignored A0=0/D4=0 mid-sequence
        write(0, 8'h11); write(0, 8'h08); write(1, 8'h40); write(0, 8'h00); write(1, 8'h02); write(1, 8'h03); idle(1);
        // asynchronous reset between ICW2 and ICW4
        write(0, 8'h13); write(1, 8'h55); idle(2);
        in_rst = 1;
        #2 reset_n = 0;
        #1;
        check("async_reset_cfg", {8'd0, dut_cfg()}, 32'd0);
        write_enable = 1; address = 1; internal_data_bus = 8'h01;
        #1;
        check("strobes_in_reset", {25'd0, dut_strobes()}, 32'd0);
        write_enable = 0;
        model_reset();
        @(posedge clock); #1;
        reset_n = 1;
        @(posedge clock); #1;
        in_rst = 0;
        write(1, 8'h01); idle(1);
        // back-to-back ICW1..ICW4
        write(0, 8'h11); write(1, 8'h40); write(1, 8'h02); write(1, 8'h03); idle(2);
        // random traffic; A0=1 favoured so sequences complete
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) idle(1);
            else write($urandom_range(0, 2) != 0, 8'($urandom));
        end
        idle(3);
        check("queue_drained", q_strobe.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
